// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, one 8-bit full-duplex frame per start request
module spi_master #(
   parameter int DATAWIDTH_BUS = 8,
   parameter int HALF_PERIOD   = 8,
   parameter int STATE_SIZE    = 3
) (
   input  logic                     SPI_MASTER_CLOCK_50,
   input  logic                     SPI_MASTER_RESET_InHigh,
   input  logic                     SPI_MASTER_start_In,
   input  logic [DATAWIDTH_BUS-1:0] SPI_MASTER_data_In,
   input  logic                     SPI_MASTER_MISO_In,
   output logic                     SPI_MASTER_SCK_Out,
   output logic                     SPI_MASTER_SS_OutLow,
   output logic                     SPI_MASTER_MOSI_Out,
   output logic                     SPI_MASTER_busy_Out,
   output logic                     SPI_MASTER_done_Out,
   output logic [DATAWIDTH_BUS-1:0] SPI_MASTER_data_Out
);
   typedef enum logic [STATE_SIZE-1:0] {
      IDLE  = STATE_SIZE'(0),
      SETUP = STATE_SIZE'(1),
      HIGH  = STATE_SIZE'(2),
      LOW   = STATE_SIZE'(3),
      HOLD  = STATE_SIZE'(4),
      GAP   = STATE_SIZE'(5)
   } state_t;

   localparam logic [7:0] LAST_PHASE = 8'(HALF_PERIOD - 1);

   state_t                   state_q, state_d;
   logic [7:0]               phase_q, phase_d;
   logic [2:0]               bit_q, bit_d;
   logic [DATAWIDTH_BUS-1:0] tx_q, tx_d;
   logic [DATAWIDTH_BUS-1:0] rx_q, rx_d;
   logic [DATAWIDTH_BUS-1:0] data_q, data_d;
   logic                     miso_q, miso_d;
   logic                     sck_q, sck_d;
   logic                     ss_q, ss_d;
   logic                     mosi_q, mosi_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     phase_end;

   assign phase_end = (phase_q == LAST_PHASE);
   assign miso_d    = SPI_MASTER_MISO_In;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q + 8'd1;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      data_d  = data_q;
      sck_d   = sck_q;
      ss_d    = ss_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            phase_d = 8'd0;
            sck_d   = 1'b0;
            ss_d    = 1'b1;
            mosi_d  = 1'b1;
            if (SPI_MASTER_start_In) begin
               tx_d    = SPI_MASTER_data_In;
               mosi_d  = SPI_MASTER_data_In[DATAWIDTH_BUS-1];
               ss_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = SETUP;
            end
         end
         // SETUP and LOW both end on a rising SCK edge that samples the flopped MISO
         SETUP, LOW: begin
            if (phase_end) begin
               phase_d = 8'd0;
               sck_d   = 1'b1;
               rx_d    = {rx_q[DATAWIDTH_BUS-2:0], miso_q};
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (phase_end) begin
               phase_d = 8'd0;
               sck_d   = 1'b0;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = HOLD;
               end else begin
                  tx_d    = {tx_q[DATAWIDTH_BUS-2:0], 1'b0};
                  mosi_d  = tx_q[DATAWIDTH_BUS-2];
                  state_d = LOW;
               end
            end
         end
         HOLD: begin
            if (phase_end) begin
               phase_d = 8'd0;
               ss_d    = 1'b1;
               mosi_d  = 1'b1;
               data_d  = rx_q;
               done_d  = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            if (phase_end) begin
               phase_d = 8'd0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = 8'd0;
            bit_d   = 3'd0;
            tx_d    = '0;
            rx_d    = '0;
            data_d  = '0;
            sck_d   = 1'b0;
            ss_d    = 1'b1;
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge SPI_MASTER_CLOCK_50) begin
      if (SPI_MASTER_RESET_InHigh) begin
         state_q <= IDLE;
         phase_q <= 8'd0;
         bit_q   <= 3'd0;
         tx_q    <= '0;
         rx_q    <= '0;
         data_q  <= '0;
         miso_q  <= 1'b0;
         sck_q   <= 1'b0;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         miso_q  <= miso_d;
         sck_q   <= sck_d;
         ss_q    <= ss_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign SPI_MASTER_SCK_Out   = sck_q;
   assign SPI_MASTER_SS_OutLow = ss_q;
   assign SPI_MASTER_MOSI_Out  = mosi_q;
   assign SPI_MASTER_busy_Out  = busy_q;
   assign SPI_MASTER_done_Out  = done_q;
   assign SPI_MASTER_data_Out  = data_q;
endmodule

// File: doc/spi_master.md
# spi_master

SPI master that frames one 8-bit full-duplex transfer per request and drives the SS/SCK/MOSI lines of the team's SPI slave, capturing MISO back. It sits upstream of the slave. A local controller issues a start pulse with a transmit byte and receives the byte returned by the slave, plus a one-cycle done strobe. The bus runs in mode 0: SCK idles low, both sides sample on the rising edge, both sides change data on the falling edge, MSB first.

## Interface
- DATAWIDTH_BUS, 8: transfer width in bits. Only 8 is supported.
- HALF_PERIOD, 8: system clocks per SCK half-period.
  - Legal range 6..255.
  - The minimum of 6 covers the slave's input-registering latency.
- STATE_SIZE, 3: state register width.

- SPI_MASTER_CLOCK_50  in  1  system clock; one clock only.
- SPI_MASTER_RESET_InHigh  in  1  synchronous, active-high reset.
- SPI_MASTER_start_In  in  1  transfer request; sampled only in IDLE.
- SPI_MASTER_data_In  in  8  byte to transmit; latched when start is accepted.
- SPI_MASTER_MISO_In  in  1  serial data from the slave.
- SPI_MASTER_SCK_Out  out  1  serial clock, registered.
- SPI_MASTER_SS_OutLow  out  1  slave select, active low, registered.
- SPI_MASTER_MOSI_Out  out  1  serial data to the slave, registered.
- SPI_MASTER_busy_Out  out  1  high from start acceptance through the inter-frame gap.
- SPI_MASTER_done_Out  out  1  one-cycle pulse when data_Out is updated.
- SPI_MASTER_data_Out  out  8  last received byte; holds its value between transfers.

## Operation
- Reset values (synchronous; applied at the first clock edge with reset high, including mid-transfer):
  - SCK=0, SS_OutLow=1, MOSI=1, busy=0, done=0, data_Out=0x00.
  - State=IDLE; phase counter, bit counter and both shift registers cleared.
- MISO_In passes through one input flop. All MISO sampling uses that flopped value.
- States:
  - IDLE: SS high, SCK low, MOSI high.
    - On start_In=1: tx shift <= data_In, MOSI <= data_In[7], SS <= 0, busy <= 1, go to SETUP.
  - SETUP: wait HALF_PERIOD cycles.
    - On the last cycle: SCK <= 1, rx <= {rx[6:0], MISO_flop}, go to HIGH.
  - HIGH: wait HALF_PERIOD cycles.
    - On the last cycle: SCK <= 0, bit counter +1.
    - If bits remain: MOSI <= next tx bit (MSB first), go to LOW.
    - After the 8th bit: go to HOLD.
  - LOW: wait HALF_PERIOD cycles.
    - On the last cycle: SCK <= 1, sample MISO into rx, go to HIGH.
  - HOLD: wait HALF_PERIOD cycles. SCK stays low and MOSI holds bit0.
    - On the last cycle: SS <= 1, MOSI <= 1, data_Out <= rx, done <= 1, go to GAP.
  - GAP: done <= 0. Wait HALF_PERIOD cycles, then busy <= 0 and go to IDLE.
  - Any undefined state encoding returns to IDLE with all outputs at their reset values.
- Boundary rules:
  - start_In outside IDLE is ignored, not queued.
  - data_In changes after acceptance have no effect.
  - If start_In is held high, the next transfer is accepted on the first IDLE cycle.
  - Phase counter runs 0..HALF_PERIOD-1 and wraps to 0 on every phase change. It is 8 bits wide.
  - Bit counter is 3 bits. The transfer ends when the counter wraps from 7 to 0 at the 8th falling edge.

## Timing
- Let T0 be the clock edge that accepts start and H = HALF_PERIOD.
- Immediately after T0: SS_OutLow=0, MOSI=data_In[7], busy=1.
- Rising SCK edge k (k=0..7) occurs at T0 + H·(2k+1).
  - MISO is captured at that same edge, so the captured value is the flopped MISO from the prior cycle.
- Falling SCK edge k occurs at T0 + H·(2k+2).
  - MOSI changes to the next bit at falling edges 0..6.
- At T0 + 17H: SS_OutLow=1, MOSI=1, data_Out valid, done=1 for exactly one cycle.
- At T0 + 18H: busy=0. The earliest next acceptance is at T0 + 18H + 1 cycle.
- Worked example, H=8: first rise at T0+8, SS release at T0+136, busy low at T0+144.

## Test plan
- Loopback (MOSI wired to MISO), H=8, start with data_In=0xA5.
  - data_Out=0xA5 and done pulses once at T0+136.
  - SCK edges exactly at T0+8, 16, …, 128.
  - SS low exactly for the window T0..T0+136.
- Against an instance of the team's SPI slave: master sends 0x3C, slave data_In=0xC3.
  - Slave data_Out=0x3C with one newData pulse.
  - Master data_Out=0xC3.
  - Repeat at H=6.
- MISO tied to 0, then tied to 1: data_Out=0x00, then 0xFF.
- start pulsed at T0+40 (mid-transfer) with data_In=0x11.
  - The pulse is ignored: exactly one frame, done pulses once, and MOSI carries only the original byte.
- start held high continuously: second SS falling edge at T0+144+1, and back-to-back frames are identical.
- Reset asserted at T0+56 (during bit 3):
  - Next edge: SCK=0, SS_OutLow=1, MOSI=1, busy=0, done=0, data_Out=0x00.
  - After reset is released, a fresh transfer completes correctly.
